// File: rtl/fifo_n_param.sv
// fifo_n_param
//   Parametrised N-entry FIFO channel with the in_enq / out_deq ENA/RDY method
//   interface. It is a drop-in successor to the fixed one-entry FIFO wrapper,
//   so existing rule-generated designs can use it unchanged.
//
//   Parameters
//     WIDTH     payload width in bits (>=1)
//     DEPTH     number of entries, power of two, >=2
//     PIPELINE  1: enqueue is also accepted when full if a dequeue fires this cycle
//     AF_LEVEL  almost_full asserts when count >= AF_LEVEL (1..DEPTH)
//
//   Ports
//     CLK             in   clock, rising edge
//     RST             in   asynchronous reset, active-high
//     in_enq__ENA     in   enqueue strobe, legal only while in_enq__RDY=1
//     in_enq_v        in   enqueue payload
//     in_enq__RDY     out  enqueue permitted this cycle
//     out_deq__ENA    in   dequeue strobe, legal only while out_deq__RDY=1
//     out_deq__RDY    out  dequeue permitted (FIFO non-empty)
//     out_first       out  head entry, 0 when empty
//     out_first__RDY  out  head valid (same as out_deq__RDY)
//     clear           in   synchronous flush, overrides enq/deq in the same cycle
//     count           out  occupancy 0..DEPTH
//     almost_full     out  count >= AF_LEVEL
module fifo_n_param #(
    parameter int WIDTH    = 15,
    parameter int DEPTH    = 4,
    parameter int PIPELINE = 0,
    parameter int AF_LEVEL = 3,
    localparam int CW      = $clog2(DEPTH + 1),
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_enq__ENA,
    input  logic [WIDTH-1:0] in_enq_v,
    output logic             in_enq__RDY,
    input  logic             out_deq__ENA,
    output logic             out_deq__RDY,
    output logic [WIDTH-1:0] out_first,
    output logic             out_first__RDY,
    input  logic             clear,
    output logic [CW-1:0]    count,
    output logic             almost_full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             full;
    logic             empty;
    logic             pipe_mode;
    logic             enq_fire;
    logic             deq_fire;

    // The count register alone decides full/empty, so the pointers can wrap
    // freely without needing an extra wrap bit to tell full from empty.
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign pipe_mode = (PIPELINE != 0);

    // In pipeline mode a full FIFO can still take a word, because the
    // dequeue firing this cycle frees the slot the write lands in.
    assign in_enq__RDY    = !full || (pipe_mode && out_deq__ENA);
    assign out_deq__RDY   = !empty;
    assign out_first__RDY = !empty;

    // Strobes raised while not ready are ignored rather than acted on.
    assign enq_fire = in_enq__ENA && in_enq__RDY;
    assign deq_fire = out_deq__ENA && !empty;

    assign out_first   = empty ? '0 : mem[rptr];
    assign almost_full = (count >= CW'(AF_LEVEL));

    // Storage is not reset; only the pointers and count define what is valid.
    always_ff @(posedge CLK) begin
        if (enq_fire && !clear) begin
            mem[wptr] <= in_enq_v;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (enq_fire) begin
                wptr <= wptr + AW'(1);
            end
            if (deq_fire) begin
                rptr <= rptr + AW'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Protocol checks: a strobe must only be raised while its RDY is high.
    a_enq_protocol : assert property (@(posedge CLK) disable iff (RST)
        !(in_enq__ENA && !in_enq__RDY));
    a_deq_protocol : assert property (@(posedge CLK) disable iff (RST)
        !(out_deq__ENA && !out_deq__RDY));

endmodule

// File: tb/tb_fifo_n_param.sv
// tb_fifo_n_param
//   Four fifo_n_param instances with different DEPTH / PIPELINE / AF_LEVEL
//   settings are driven from one stimulus process. A queue per instance holds
//   the reference contents; a second queue per instance holds the words
//   expected to leave the FIFO, and a monitor process pops it on each dequeue.
module tb_fifo_n_param;

    localparam int NI = 4;
    localparam int DEP [NI] = '{4, 4, 2, 16};
    localparam int PIP [NI] = '{0, 1, 1, 0};
    localparam int AFL [NI] = '{3, 3, 2, 12};

    logic        CLK = 1'b0;
    logic        RST = 1'b1;

    logic        enq_ena [NI];
    logic [14:0] enq_v   [NI];
    logic        deq_ena [NI];
    logic        clr     [NI];
    logic        enq_rdy [NI];
    logic        deq_rdy [NI];
    logic        first_rdy [NI];
    logic [14:0] first_w [NI];
    logic        af      [NI];
    logic [4:0]  cnt_x   [NI];

    logic [2:0]  cnt0;
    logic [2:0]  cnt1;
    logic [1:0]  cnt2;
    logic [4:0]  cnt3;

    logic [14:0] mdl   [NI][$];
    logic [14:0] exp_q [NI][$];

    int checks = 0;
    int errors = 0;
    int mon_sz;
    logic [14:0] mon_word;

    always #5 CLK = ~CLK;

    fifo_n_param #(.WIDTH(15), .DEPTH(4), .PIPELINE(0), .AF_LEVEL(3)) u_d4_p0 (
        .CLK(CLK), .RST(RST),
        .in_enq__ENA(enq_ena[0]), .in_enq_v(enq_v[0]), .in_enq__RDY(enq_rdy[0]),
        .out_deq__ENA(deq_ena[0]), .out_deq__RDY(deq_rdy[0]),
        .out_first(first_w[0]), .out_first__RDY(first_rdy[0]),
        .clear(clr[0]), .count(cnt0), .almost_full(af[0]));

    fifo_n_param #(.WIDTH(15), .DEPTH(4), .PIPELINE(1), .AF_LEVEL(3)) u_d4_p1 (
        .CLK(CLK), .RST(RST),
        .in_enq__ENA(enq_ena[1]), .in_enq_v(enq_v[1]), .in_enq__RDY(enq_rdy[1]),
        .out_deq__ENA(deq_ena[1]), .out_deq__RDY(deq_rdy[1]),
        .out_first(first_w[1]), .out_first__RDY(first_rdy[1]),
        .clear(clr[1]), .count(cnt1), .almost_full(af[1]));

    fifo_n_param #(.WIDTH(15), .DEPTH(2), .PIPELINE(1), .AF_LEVEL(2)) u_d2_p1 (
        .CLK(CLK), .RST(RST),
        .in_enq__ENA(enq_ena[2]), .in_enq_v(enq_v[2]), .in_enq__RDY(enq_rdy[2]),
        .out_deq__ENA(deq_ena[2]), .out_deq__RDY(deq_rdy[2]),
        .out_first(first_w[2]), .out_first__RDY(first_rdy[2]),
        .clear(clr[2]), .count(cnt2), .almost_full(af[2]));

    fifo_n_param #(.WIDTH(15), .DEPTH(16), .PIPELINE(0), .AF_LEVEL(12)) u_d16_p0 (
        .CLK(CLK), .RST(RST),
        .in_enq__ENA(enq_ena[3]), .in_enq_v(enq_v[3]), .in_enq__RDY(enq_rdy[3]),
        .out_deq__ENA(deq_ena[3]), .out_deq__RDY(deq_rdy[3]),
        .out_first(first_w[3]), .out_first__RDY(first_rdy[3]),
        .clear(clr[3]), .count(cnt3), .almost_full(af[3]));

    assign cnt_x[0] = 5'(cnt0);
    assign cnt_x[1] = 5'(cnt1);
    assign cnt_x[2] = 5'(cnt2);
    assign cnt_x[3] = cnt3;

    task automatic checkOutput(input string name, input int inst,
                               input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s inst%0d at %0t: got 0x%0h, expected 0x%0h",
                     name, inst, $time, actual, expected);
        end
    endtask

    // Everything expected is computed from the reference queue contents.
    always @(negedge CLK) begin
        for (int i = 0; i < NI; i++) begin
            mon_sz = mdl[i].size();
            checkOutput("count", i, cnt_x[i], mon_sz);
            checkOutput("deq_rdy", i, deq_rdy[i], mon_sz > 0);
            checkOutput("first_rdy", i, first_rdy[i], mon_sz > 0);
            checkOutput("almost_full", i, af[i], mon_sz >= AFL[i]);
            checkOutput("enq_rdy", i, enq_rdy[i],
                        (mon_sz < DEP[i]) || (PIP[i] != 0 && deq_ena[i]));
            checkOutput("first", i, first_w[i], (mon_sz > 0) ? mdl[i][0] : 15'd0);
            if (deq_ena[i] && deq_rdy[i] && !clr[i] && !RST) begin
                if (exp_q[i].size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL deq_data inst%0d at %0t: dequeue with no expected word",
                             i, $time);
                end else begin
                    mon_word = exp_q[i].pop_front();
                    checkOutput("deq_data", i, first_w[i], mon_word);
                end
            end
        end
    end

    task automatic idleAll();
        for (int i = 0; i < NI; i++) begin
            enq_ena[i] = 1'b0;
            deq_ena[i] = 1'b0;
            clr[i]     = 1'b0;
            enq_v[i]   = 15'd0;
        end
    endtask

    // Strobes are only raised when the reference model says they are legal.
    task automatic applyStimulus(input int i, input logic e, input logic [14:0] v,
                                 input logic d, input logic c);
        logic d_ok;
        logic e_ok;
        d_ok = d && (mdl[i].size() > 0);
        e_ok = e && ((mdl[i].size() < DEP[i]) || (PIP[i] != 0 && d_ok));
        deq_ena[i] = d_ok;
        enq_ena[i] = e_ok;
        enq_v[i]   = v;
        clr[i]     = c;
        if (e_ok && !c) exp_q[i].push_back(v);
    endtask

    // Advance one clock and apply what the edge did to the reference queues.
    task automatic tick();
        logic [14:0] dummy;
        @(posedge CLK);
        #1;
        for (int i = 0; i < NI; i++) begin
            if (RST || clr[i]) begin
                mdl[i].delete();
                exp_q[i].delete();
            end else begin
                if (deq_ena[i]) dummy = mdl[i].pop_front();
                if (enq_ena[i]) mdl[i].push_back(enq_v[i]);
            end
        end
        #1;
    endtask

    task automatic doReset(input int cycles);
        idleAll();
        RST = 1'b1;
        for (int i = 0; i < NI; i++) begin
            mdl[i].delete();
            exp_q[i].delete();
        end
        for (int n = 0; n < cycles; n++) tick();
        RST = 1'b0;
    endtask

    task automatic bothD4(input logic e, input logic [14:0] v, input logic d, input logic c);
        tick();
        idleAll();
        applyStimulus(0, e, v, d, c);
        applyStimulus(1, e, v, d, c);
    endtask

    initial begin
        idleAll();
        tick();
        doReset(2);

        // Fill to DEPTH, hold full one cycle, then drain in order.
        for (int k = 1; k <= 4; k++) bothD4(1'b1, 15'(k), 1'b0, 1'b0);
        bothD4(1'b0, 15'd0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) bothD4(1'b0, 15'd0, 1'b1, 1'b0);
        bothD4(1'b0, 15'd0, 1'b0, 1'b0);

        // Ten enq/deq pairs at count 2 walk the pointers across the wrap.
        bothD4(1'b1, 15'h0010, 1'b0, 1'b0);
        bothD4(1'b1, 15'h0011, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) bothD4(1'b1, 15'(16'h0020 + k), 1'b1, 1'b0);
        bothD4(1'b0, 15'd0, 1'b1, 1'b0);
        bothD4(1'b0, 15'd0, 1'b1, 1'b0);

        // Full FIFO with enq 0x7FFF and deq together: pipeline takes it, the other refuses.
        for (int k = 1; k <= 4; k++) bothD4(1'b1, 15'(16'h0100 + k), 1'b0, 1'b0);
        bothD4(1'b1, 15'h7FFF, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) bothD4(1'b0, 15'd0, 1'b1, 1'b0);
        bothD4(1'b0, 15'd0, 1'b1, 1'b0);

        // Clear at count 3 beats a simultaneous enq and deq.
        for (int k = 1; k <= 3; k++) bothD4(1'b1, 15'(16'h0200 + k), 1'b0, 1'b0);
        bothD4(1'b1, 15'h0255, 1'b1, 1'b1);
        bothD4(1'b0, 15'd0, 1'b0, 1'b0);
        bothD4(1'b1, 15'h0300, 1'b0, 1'b0);
        bothD4(1'b0, 15'd0, 1'b1, 1'b0);

        // Reset held for 3 cycles in the middle of traffic; the next edge must accept enq.
        bothD4(1'b1, 15'h0401, 1'b0, 1'b0);
        bothD4(1'b1, 15'h0402, 1'b1, 1'b0);
        tick();
        doReset(3);
        applyStimulus(0, 1'b1, 15'h0555, 1'b0, 1'b0);
        applyStimulus(1, 1'b1, 15'h0555, 1'b0, 1'b0);
        bothD4(1'b0, 15'd0, 1'b1, 1'b0);
        bothD4(1'b0, 15'd0, 1'b0, 1'b0);

        // Random traffic on all four instances with rare clears and one reset.
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (cyc == 5000) begin
                tick();
                doReset(2);
            end
            tick();
            idleAll();
            for (int i = 0; i < NI; i++) begin
                applyStimulus(i,
                              $urandom_range(0, 99) < 55,
                              15'($urandom),
                              $urandom_range(0, 99) < 50,
                              $urandom_range(0, 199) == 0);
            end
        end
        tick();
        idleAll();
        tick();

        $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
